song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Playback controller that sequences the note-ROM address for a multi-song hardware music player.
- Holds a song table of base/last addresses and advances the address one step per beat tick.
- Handles play/pause/stop/next/prev commands, inserts a silent gap between songs, and either repeats the current song or auto-advances.
- Sits between the debounced front-panel keys / beat divider and the note ROM plus tone divider.

Parameters:
- NUM_SONGS, 4, songs in table (1..4).
- S0_BASE / S0_LAST, 0 / 138, address range of song 0.
- S1_BASE / S1_LAST, 139 / 255, address range of song 1.
- S2_BASE / S2_LAST, 0 / 63, address range of song 2.
- S3_BASE / S3_LAST, 64 / 138, address range of song 3.
- GAP_BEATS, 4, silent beats between songs (1..15).
- RESTART_THRESH, 8, PREV restarts the current song if offset >= this value, else selects the previous song.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- BEAT_EN  in  1  single-cycle beat tick (e.g. 4 Hz).
- KEY_PLAY, KEY_STOP, KEY_NEXT, KEY_PREV  in  1 each  level keys, active-high, asynchronous to CLK.
- AUTO_ADV  in  1  0 = repeat current song at end, 1 = advance to next song (wraps).
- ADDR  out  8  note-ROM address.
- SONG_ID  out  2  current song index.
- PLAYING  out  1  high in PLAY.
- MUTE  out  1  high in every state except PLAY.
- SONG_END  out  1  one-cycle pulse when the last note of a song completes.

Behaviour:
- Reset values: state IDLE, SONG_ID=0, ADDR=S0_BASE, PLAYING=0, MUTE=1, SONG_END=0, gap counter=0.
- Keys: each key passes through a 2-flop synchronizer and a rising-edge detector, giving a 1-cycle command pulse 3 CLK cycles after the key edge.
- States:
  - IDLE: stopped.
  - PLAY: address advancing.
  - PAUSE: address frozen.
  - GAP: inter-song silence.
- Command priority for simultaneous pulses: STOP > NEXT > PREV > PLAY. Exactly one command acts per cycle.
- Any command pulse in a cycle suppresses that cycle's BEAT_EN.
- Commands take effect on the CLK edge after the pulse. All outputs are registered.
- PLAY:
  - IDLE -> PLAY; ADDR=base(SONG_ID).
  - PLAY -> PAUSE.
  - PAUSE -> PLAY; ADDR unchanged.
  - GAP -> PLAY immediately, loading the pending song's base.
- STOP: from any state -> IDLE; ADDR=base(SONG_ID); gap counter cleared.
- NEXT:
  - SONG_ID=(SONG_ID+1) mod NUM_SONGS; ADDR=base(new).
  - IDLE and PAUSE keep their state; PLAY stays PLAY; GAP -> PLAY.
- PREV:
  - If (ADDR-base) >= RESTART_THRESH, ADDR=base(SONG_ID).
  - Otherwise SONG_ID=(SONG_ID+NUM_SONGS-1) mod NUM_SONGS and ADDR=base(new).
  - State transitions are the same as NEXT.
- PLAY with BEAT_EN:
  - If ADDR != last(SONG_ID), ADDR<=ADDR+1.
  - If ADDR == last(SONG_ID): SONG_END=1 for that cycle, ADDR held, state -> GAP, gap counter=0.
  - No 8-bit wrap is ever performed. Last=255 is handled by the compare, not by overflow.
- GAP with BEAT_EN:
  - Gap counter increments.
  - When it reaches GAP_BEATS: SONG_ID = AUTO_ADV ? next : same; ADDR=base(SONG_ID); state -> PLAY.
  - AUTO_ADV is sampled at that cycle.
- Out-of-range guard: if SONG_ID >= NUM_SONGS (only reachable through a parameter change), the FSM forces SONG_ID=0 on the next cycle.
- BEAT_EN is ignored in IDLE and PAUSE.
- Asynchronous reset mid-song restores all reset values immediately.

Decomposition:
- Package song_seq_pkg holds:
  - State encoding: IDLE=2'd0, PLAY=2'd1, PAUSE=2'd2, GAP=2'd3.
  - Command codes.
  - Song-table base/last lookup functions indexed by SONG_ID.
- Sub-module key_pulse: synchronizer plus edge detector, one instance per key, outputs a 1-cycle pulse.

Test Plan:
- Reset, PLAY, 139 BEAT_EN ticks on song 0 -> ADDR counts 0..138, with SONG_END pulse on tick 139. Then with AUTO_ADV=1 and 4 further ticks -> SONG_ID=1, ADDR=139, PLAYING=1.
- Song 1 at ADDR=255 with BEAT_EN, AUTO_ADV=0 -> SONG_END pulses, GAP, no wrap to 0. After 4 beats -> ADDR=139, SONG_ID=1.
- PLAY at ADDR=20, then PLAY again 10 beats later -> ADDR stays 20 during PAUSE with MUTE=1; third PLAY resumes at 20.
- Song 2 at ADDR=5 (offset 5), PREV -> SONG_ID=1, ADDR=139. Song 1 at ADDR=150 (offset 11), PREV -> ADDR=139, SONG_ID=1.
- STOP, NEXT and BEAT_EN asserted in the same cycle during PLAY -> IDLE, ADDR=base(current), no increment, SONG_ID unchanged.
- NEXT in GAP state, and RST asserted mid-song -> GAP exits to PLAY at the next song's base. RST returns ADDR=0, SONG_ID=0, MUTE=1 asynchronously.

Source files
------------

// File: rtl/song_seq_pkg.sv
`default_nettype none
// ============================================================================
// song_seq_pkg : state/command encodings and song-table lookup helpers
// Revision 1.0
// ============================================================================
package song_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_STOP = 3'd1,
        CMD_NEXT = 3'd2,
        CMD_PREV = 3'd3,
        CMD_PLAY = 3'd4
    } cmd_e;

    localparam int c_key_stop = 0;
    localparam int c_key_next = 1;
    localparam int c_key_prev = 2;
    localparam int c_key_play = 3;

    // Pulse vector bit order is {play, prev, next, stop}; lower bits win.
    function automatic cmd_e decode_cmd(input logic [3:0] pulses);
        cmd_e cmd;
        cmd = CMD_NONE;
        if (pulses[c_key_stop])      cmd = CMD_STOP;
        else if (pulses[c_key_next]) cmd = CMD_NEXT;
        else if (pulses[c_key_prev]) cmd = CMD_PREV;
        else if (pulses[c_key_play]) cmd = CMD_PLAY;
        return cmd;
    endfunction

    // Table packs four 8-bit addresses, song 0 in the low byte.
    function automatic logic [7:0] tbl_lookup(input logic [31:0] tbl, input logic [1:0] id);
        return tbl[{id, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_pulse.sv
`default_nettype none
// ============================================================================
// key_pulse : 2-flop synchronizer plus rising-edge detector for one key
// Revision 1.0
// ============================================================================
module key_pulse (
    input  logic CLK,
    input  logic RST,
    input  logic key,
    output logic pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;
    logic r_pulse;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= key;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_pulse <= r_sync2 & ~r_sync3;
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// song_sequencer : beat-driven note-ROM address sequencer with play/pause/stop/next/prev
// Revision 1.0
// ============================================================================
module song_sequencer
    import song_seq_pkg::*;
#(
    parameter int NUM_SONGS      = 4,
    parameter int S0_BASE        = 0,
    parameter int S0_LAST        = 138,
    parameter int S1_BASE        = 139,
    parameter int S1_LAST        = 255,
    parameter int S2_BASE        = 0,
    parameter int S2_LAST        = 63,
    parameter int S3_BASE        = 64,
    parameter int S3_LAST        = 138,
    parameter int GAP_BEATS      = 4,
    parameter int RESTART_THRESH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BEAT_EN,
    input  logic       KEY_PLAY,
    input  logic       KEY_STOP,
    input  logic       KEY_NEXT,
    input  logic       KEY_PREV,
    input  logic       AUTO_ADV,
    output logic [7:0] ADDR,
    output logic [1:0] SONG_ID,
    output logic       PLAYING,
    output logic       MUTE,
    output logic       SONG_END
);

    localparam logic [31:0] c_base_tbl = {8'(S3_BASE), 8'(S2_BASE), 8'(S1_BASE), 8'(S0_BASE)};
    localparam logic [31:0] c_last_tbl = {8'(S3_LAST), 8'(S2_LAST), 8'(S1_LAST), 8'(S0_LAST)};
    localparam logic [1:0]  c_last_id  = 2'(NUM_SONGS - 1);
    localparam logic [2:0]  c_num      = 3'(NUM_SONGS);
    localparam logic [3:0]  c_gap      = 4'(GAP_BEATS);
    localparam logic [7:0]  c_restart  = 8'(RESTART_THRESH);

    logic [3:0] w_keys;
    logic [3:0] w_pulse;

    assign w_keys = {KEY_PLAY, KEY_PREV, KEY_NEXT, KEY_STOP};

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_pulse u_key (
            .CLK   (CLK),
            .RST   (RST),
            .key   (w_keys[gi]),
            .pulse (w_pulse[gi])
        );
    end

    state_e     r_state;
    logic [1:0] r_song;
    logic [7:0] r_addr;
    logic [3:0] r_gap;
    logic       r_song_end;
    logic       r_playing;
    logic       r_mute;

    cmd_e       w_cmd;
    state_e     w_state_n;
    logic [1:0] w_song_n;
    logic [7:0] w_addr_n;
    logic [3:0] w_gap_n;
    logic       w_end_n;
    logic [1:0] w_song_next;
    logic [1:0] w_song_prev;
    logic [1:0] w_song_pend;
    logic [7:0] w_base_cur;
    logic [7:0] w_last_cur;
    logic [7:0] w_offset;
    logic [3:0] w_gap_inc;

    always_comb begin
        w_cmd       = decode_cmd(w_pulse);
        w_song_next = (r_song >= c_last_id) ? 2'd0 : r_song + 2'd1;
        w_song_prev = (r_song == 2'd0) ? c_last_id : r_song - 2'd1;
        w_song_pend = AUTO_ADV ? w_song_next : r_song;
        w_base_cur  = tbl_lookup(c_base_tbl, r_song);
        w_last_cur  = tbl_lookup(c_last_tbl, r_song);
        w_offset    = r_addr - w_base_cur;
        w_gap_inc   = r_gap + 4'd1;

        w_state_n = r_state;
        w_song_n  = r_song;
        w_addr_n  = r_addr;
        w_gap_n   = r_gap;
        w_end_n   = 1'b0;

        // A command cycle never also consumes a beat.
        case (w_cmd)
            CMD_STOP: begin
                w_state_n = S_IDLE;
                w_addr_n  = w_base_cur;
                w_gap_n   = 4'd0;
            end
            CMD_NEXT, CMD_PREV: begin
                if (w_cmd == CMD_PREV && w_offset >= c_restart) begin
                    w_addr_n = w_base_cur;
                end else begin
                    w_song_n = (w_cmd == CMD_NEXT) ? w_song_next : w_song_prev;
                    w_addr_n = tbl_lookup(c_base_tbl, w_song_n);
                end
                if (r_state == S_GAP) begin
                    w_state_n = S_PLAY;
                    w_gap_n   = 4'd0;
                end
            end
            CMD_PLAY: begin
                case (r_state)
                    S_IDLE: begin
                        w_state_n = S_PLAY;
                        w_addr_n  = w_base_cur;
                    end
                    S_PLAY:  w_state_n = S_PAUSE;
                    S_PAUSE: w_state_n = S_PLAY;
                    S_GAP: begin
                        w_state_n = S_PLAY;
                        w_song_n  = w_song_pend;
                        w_addr_n  = tbl_lookup(c_base_tbl, w_song_pend);
                        w_gap_n   = 4'd0;
                    end
                    default: w_state_n = S_IDLE;
                endcase
            end
            default: begin
                if (BEAT_EN && r_state == S_PLAY) begin
                    if (r_addr == w_last_cur) begin
                        w_end_n   = 1'b1;
                        w_state_n = S_GAP;
                        w_gap_n   = 4'd0;
                    end else begin
                        w_addr_n = r_addr + 8'd1;
                    end
                end else if (BEAT_EN && r_state == S_GAP) begin
                    w_gap_n = w_gap_inc;
                    if (w_gap_inc >= c_gap) begin
                        w_state_n = S_PLAY;
                        w_song_n  = w_song_pend;
                        w_addr_n  = tbl_lookup(c_base_tbl, w_song_pend);
                        w_gap_n   = 4'd0;
                    end
                end
            end
        endcase

        // Only reachable when NUM_SONGS shrinks below the stored index.
        if ({1'b0, r_song} >= c_num) begin
            w_song_n = 2'd0;
            w_addr_n = tbl_lookup(c_base_tbl, 2'd0);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_song     <= 2'd0;
            r_addr     <= 8'(S0_BASE);
            r_gap      <= 4'd0;
            r_song_end <= 1'b0;
            r_playing  <= 1'b0;
            r_mute     <= 1'b1;
        end else begin
            r_state    <= w_state_n;
            r_song     <= w_song_n;
            r_addr     <= w_addr_n;
            r_gap      <= w_gap_n;
            r_song_end <= w_end_n;
            r_playing  <= (w_state_n == S_PLAY);
            r_mute     <= (w_state_n != S_PLAY);
        end
    end

    assign ADDR     = r_addr;
    assign SONG_ID  = r_song;
    assign PLAYING  = r_playing;
    assign MUTE     = r_mute;
    assign SONG_END = r_song_end;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// ============================================================================
// tb_song_sequencer : directed scoreboard bench for song_sequencer
// Revision 1.0
// ============================================================================
module tb_song_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       BEAT_EN = 1'b0;
    logic       KEY_PLAY = 1'b0;
    logic       KEY_STOP = 1'b0;
    logic       KEY_NEXT = 1'b0;
    logic       KEY_PREV = 1'b0;
    logic       AUTO_ADV = 1'b0;
    logic [7:0] ADDR;
    logic [1:0] SONG_ID;
    logic       PLAYING;
    logic       MUTE;
    logic       SONG_END;

    song_sequencer dut (
        .CLK      (CLK),
        .RST      (RST),
        .BEAT_EN  (BEAT_EN),
        .KEY_PLAY (KEY_PLAY),
        .KEY_STOP (KEY_STOP),
        .KEY_NEXT (KEY_NEXT),
        .KEY_PREV (KEY_PREV),
        .AUTO_ADV (AUTO_ADV),
        .ADDR     (ADDR),
        .SONG_ID  (SONG_ID),
        .PLAYING  (PLAYING),
        .MUTE     (MUTE),
        .SONG_END (SONG_END)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        logic [7:0] addr;
        logic [1:0] song;
        logic       playing;
        logic       song_end;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam int K_PLAY = 0;
    localparam int K_STOP = 1;
    localparam int K_NEXT = 2;
    localparam int K_PREV = 3;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int a, input int s, input bit p, input bit e);
        exp_t x;
        x.tag      = tag;
        x.addr     = 8'(a);
        x.song     = 2'(s);
        x.playing  = p;
        x.song_end = e;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() == 0) begin
            cmp("sb_underflow", 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            cmp({x.tag, "/addr"},     32'(ADDR),     32'(x.addr));
            cmp({x.tag, "/song"},     32'(SONG_ID),  32'(x.song));
            cmp({x.tag, "/playing"},  32'(PLAYING),  32'(x.playing));
            cmp({x.tag, "/mute"},     32'(MUTE),     32'(!x.playing));
            cmp({x.tag, "/song_end"}, 32'(SONG_END), 32'(x.song_end));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat();
        BEAT_EN = 1'b1;
        tick();
        BEAT_EN = 1'b0;
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            K_PLAY:  KEY_PLAY = v;
            K_STOP:  KEY_STOP = v;
            K_NEXT:  KEY_NEXT = v;
            default: KEY_PREV = v;
        endcase
    endtask

    // Idle ticks let the synchronizer see the key low; the command lands on the 4th edge.
    task automatic press(input int k);
        repeat (3) tick();
        set_key(k, 1'b1);
        repeat (4) tick();
        set_key(k, 1'b0);
    endtask

    task automatic beats_expect(input string tag, input int first, input int last, input int s);
        for (int a = first; a <= last; a++) begin
            push(tag, a, s, 1'b1, 1'b0);
            beat();
            check_out();
        end
    endtask

    initial begin
        // Reset
        #12;
        push("reset", 0, 0, 1'b0, 1'b0);
        check_out();
        #1 RST = 1'b1;
        tick();

        // Song 0 full playthrough, auto-advance into song 1
        AUTO_ADV = 1'b1;
        push("play0", 0, 0, 1'b1, 1'b0);
        press(K_PLAY);
        check_out();
        beats_expect("s0", 1, 138, 0);
        push("s0_end", 138, 0, 1'b0, 1'b1);
        beat();
        check_out();
        for (int g = 1; g <= 3; g++) begin
            push("gap0", 138, 0, 1'b0, 1'b0);
            beat();
            check_out();
        end
        push("gap0_exit", 139, 1, 1'b1, 1'b0);
        beat();
        check_out();

        // Song 1 ends at 255 without wrapping, then repeats
        AUTO_ADV = 1'b0;
        beats_expect("s1", 140, 255, 1);
        push("s1_end", 255, 1, 1'b0, 1'b1);
        beat();
        check_out();
        for (int g = 1; g <= 3; g++) begin
            push("gap1", 255, 1, 1'b0, 1'b0);
            beat();
            check_out();
        end
        push("repeat", 139, 1, 1'b1, 1'b0);
        beat();
        check_out();

        // Pause / resume on song 2
        push("next_play", 0, 2, 1'b1, 1'b0);
        press(K_NEXT);
        check_out();
        beats_expect("s2", 1, 20, 2);
        push("pause", 20, 2, 1'b0, 1'b0);
        press(K_PLAY);
        check_out();
        for (int i = 0; i < 10; i++) begin
            push("paused", 20, 2, 1'b0, 1'b0);
            beat();
            check_out();
        end
        push("resume", 20, 2, 1'b1, 1'b0);
        press(K_PLAY);
        check_out();

        // PREV restart vs previous-song around the threshold
        push("prev_restart20", 0, 2, 1'b1, 1'b0);
        press(K_PREV);
        check_out();
        beats_expect("s2b", 1, 5, 2);
        push("prev_off5", 139, 1, 1'b1, 1'b0);
        press(K_PREV);
        check_out();
        beats_expect("s1b", 140, 150, 1);
        push("prev_off11", 139, 1, 1'b1, 1'b0);
        press(K_PREV);
        check_out();

        // STOP + NEXT + BEAT in the same cycle
        beats_expect("s1c", 140, 142, 1);
        repeat (3) tick();
        KEY_STOP = 1'b1;
        KEY_NEXT = 1'b1;
        repeat (3) tick();
        push("stop_next_beat", 139, 1, 1'b0, 1'b0);
        BEAT_EN = 1'b1;
        tick();
        BEAT_EN = 1'b0;
        KEY_STOP = 1'b0;
        KEY_NEXT = 1'b0;
        check_out();
        push("idle_beat", 139, 1, 1'b0, 1'b0);
        beat();
        check_out();

        push("play_idle", 139, 1, 1'b1, 1'b0);
        press(K_PLAY);
        check_out();
        beats_expect("s1d", 140, 147, 1);
        push("prev_off8", 139, 1, 1'b1, 1'b0);
        press(K_PREV);
        check_out();
        beats_expect("s1e", 140, 146, 1);
        push("prev_off7", 0, 0, 1'b1, 1'b0);
        press(K_PREV);
        check_out();

        // Index wrap in both directions
        push("prev_wrap", 64, 3, 1'b1, 1'b0);
        press(K_PREV);
        check_out();
        push("next_wrap", 0, 0, 1'b1, 1'b0);
        press(K_NEXT);
        check_out();
        push("next_s1", 139, 1, 1'b1, 1'b0);
        press(K_NEXT);
        check_out();
        push("next_s2", 0, 2, 1'b1, 1'b0);
        press(K_NEXT);
        check_out();

        // NEXT during GAP exits straight to PLAY
        beats_expect("s2c", 1, 63, 2);
        push("s2_end", 63, 2, 1'b0, 1'b1);
        beat();
        check_out();
        push("gap2", 63, 2, 1'b0, 1'b0);
        beat();
        check_out();
        push("next_in_gap", 64, 3, 1'b1, 1'b0);
        press(K_NEXT);
        check_out();
        beats_expect("s3", 65, 67, 3);

        // Asynchronous reset mid-song, away from any clock edge
        @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        push("async_rst", 0, 0, 1'b0, 1'b0);
        check_out();
        #3 RST = 1'b1;
        tick();
        push("post_rst", 0, 0, 1'b0, 1'b0);
        check_out();

        cmp("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
